// File: rtl/sata_channel_emulator.sv
// Bidirectional fixed-latency SATA channel model with a single-shot error injector.
// Build with SATA_CHANNEL_ERR_INJECT_EN defined to enable the injector.
module sata_channel_emulator #(
   parameter int DATA_WIDTH      = 32,
   parameter int LATENCY         = 4,
   parameter int ERR_COUNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      h_tx_dout,
   input  logic [DATA_WIDTH/8-1:0]    h_tx_isk,
   input  logic                       h_tx_elec_idle,
   input  logic                       h_tx_comm_reset,
   input  logic                       h_tx_comm_wake,
   output logic [DATA_WIDTH-1:0]      d_rx_din,
   output logic [DATA_WIDTH/8-1:0]    d_rx_isk,
   output logic                       d_rx_elec_idle,
   output logic                       d_comm_reset_detect,
   output logic                       d_comm_wake_detect,
   input  logic [DATA_WIDTH-1:0]      d_tx_dout,
   input  logic [DATA_WIDTH/8-1:0]    d_tx_isk,
   input  logic                       d_tx_elec_idle,
   input  logic                       d_tx_comm_reset,
   input  logic                       d_tx_comm_wake,
   output logic [DATA_WIDTH-1:0]      h_rx_din,
   output logic [DATA_WIDTH/8-1:0]    h_rx_isk,
   output logic                       h_rx_elec_idle,
   output logic                       h_comm_init_detect,
   output logic                       h_comm_wake_detect,
   input  logic                       inject_stb,
   input  logic                       inject_dir,
   input  logic [7:0]                 inject_offset,
   input  logic [DATA_WIDTH-1:0]      inject_mask,
   output logic                       inject_busy,
   output logic                       inject_done,
   output logic [ERR_COUNT_WIDTH-1:0] inject_count
);

   localparam int KW = DATA_WIDTH / 8;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KW-1:0]         isk;
      logic                  idle;
      logic                  cres;
      logic                  cwake;
   } stage_t;

   localparam stage_t IDLE_STG = '{data: '0, isk: '0, idle: 1'b1,
                                   cres: 1'b0, cwake: 1'b0};

   stage_t hd_q [LATENCY];
   stage_t hd_d [LATENCY];
   stage_t dh_q [LATENCY];
   stage_t dh_d [LATENCY];
   stage_t hd_out;
   stage_t dh_out;

   logic [DATA_WIDTH-1:0] hd_mask;
   logic [DATA_WIDTH-1:0] dh_mask;

   always_comb begin
      hd_d[0] = '{data: h_tx_dout, isk: h_tx_isk, idle: h_tx_elec_idle,
                  cres: h_tx_comm_reset, cwake: h_tx_comm_wake};
      dh_d[0] = '{data: d_tx_dout, isk: d_tx_isk, idle: d_tx_elec_idle,
                  cres: d_tx_comm_reset, cwake: d_tx_comm_wake};
      for (int i = 1; i < LATENCY; i++) begin
         hd_d[i] = hd_q[i-1];
         dh_d[i] = dh_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            hd_q[i] <= IDLE_STG;
            dh_q[i] <= IDLE_STG;
         end
      end else begin
         hd_q <= hd_d;
         dh_q <= dh_d;
      end
   end

   assign hd_out = hd_q[LATENCY-1];
   assign dh_out = dh_q[LATENCY-1];

`ifdef SATA_CHANNEL_ERR_INJECT_EN
   typedef enum logic {S_IDLE, S_ARMED} state_t;

   state_t                     state_q, state_d;
   logic                       dir_q, dir_d;
   logic [7:0]                 rem_q, rem_d;
   logic [DATA_WIDTH-1:0]      mask_q, mask_d;
   logic [ERR_COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                       tgt_active;
   logic                       hit;

   // Only non-idle words in the latched direction advance the offset.
   assign tgt_active = dir_q ? ~dh_out.idle : ~hd_out.idle;
   assign hit = (state_q == S_ARMED) && tgt_active && (rem_q == 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         rem_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (inject_stb) begin
               state_d = S_ARMED;
               dir_d   = inject_dir;
               rem_d   = inject_offset;
               mask_d  = inject_mask;
            end
         end
         S_ARMED: begin
            if (hit) begin
               state_d = S_IDLE;
               if (~&cnt_q) cnt_d = cnt_q + ERR_COUNT_WIDTH'(1);
            end else if (tgt_active) begin
               rem_d = rem_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inject_busy  = (state_q == S_ARMED);
      inject_done  = hit;
      inject_count = cnt_q;
      hd_mask      = (hit && !dir_q) ? mask_q : '0;
      dh_mask      = (hit && dir_q) ? mask_q : '0;
   end
`else
   logic unused_inject;

   assign unused_inject = ^{inject_stb, inject_dir, inject_offset, inject_mask};
   assign inject_busy   = 1'b0;
   assign inject_done   = 1'b0;
   assign inject_count  = '0;
   assign hd_mask       = '0;
   assign dh_mask       = '0;
`endif

   assign d_rx_elec_idle      = hd_out.idle;
   assign d_rx_din            = hd_out.idle ? '0 : (hd_out.data ^ hd_mask);
   assign d_rx_isk            = hd_out.idle ? '0 : hd_out.isk;
   assign d_comm_reset_detect = hd_out.cres;
   assign d_comm_wake_detect  = hd_out.cwake;

   assign h_rx_elec_idle      = dh_out.idle;
   assign h_rx_din            = dh_out.idle ? '0 : (dh_out.data ^ dh_mask);
   assign h_rx_isk            = dh_out.idle ? '0 : dh_out.isk;
   assign h_comm_init_detect  = dh_out.cres;
   assign h_comm_wake_detect  = dh_out.cwake;

endmodule

// File: tb/tb_sata_channel_emulator.sv
// Self-checking bench for sata_channel_emulator: per-cycle comparison of every
// output against a history-based channel model and an injector model.
module tb_sata_channel_emulator;

   localparam int DW  = 32;
   localparam int L   = 4;
   localparam int ECW = 2;
   localparam int KW  = DW / 8;
   localparam int N   = 2048;
   localparam int CMAX = (1 << ECW) - 1;
`ifdef SATA_CHANNEL_ERR_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          ei;
      logic          cr;
      logic          cw;
   } word_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [DW-1:0]  h_tx_dout = '0, d_tx_dout = '0;
   logic [KW-1:0]  h_tx_isk = '0, d_tx_isk = '0;
   logic           h_tx_elec_idle = 1'b1, d_tx_elec_idle = 1'b1;
   logic           h_tx_comm_reset = 1'b0, h_tx_comm_wake = 1'b0;
   logic           d_tx_comm_reset = 1'b0, d_tx_comm_wake = 1'b0;
   logic [DW-1:0]  d_rx_din, h_rx_din;
   logic [KW-1:0]  d_rx_isk, h_rx_isk;
   logic           d_rx_elec_idle, h_rx_elec_idle;
   logic           d_comm_reset_detect, d_comm_wake_detect;
   logic           h_comm_init_detect, h_comm_wake_detect;
   logic           inject_stb = 1'b0, inject_dir = 1'b0;
   logic [7:0]     inject_offset = '0;
   logic [DW-1:0]  inject_mask = '0;
   logic           inject_busy, inject_done;
   logic [ECW-1:0] inject_count;

   sata_channel_emulator #(
      .DATA_WIDTH(DW), .LATENCY(L), .ERR_COUNT_WIDTH(ECW)
   ) dut (
      .clk(clk), .rst(rst),
      .h_tx_dout(h_tx_dout), .h_tx_isk(h_tx_isk),
      .h_tx_elec_idle(h_tx_elec_idle),
      .h_tx_comm_reset(h_tx_comm_reset), .h_tx_comm_wake(h_tx_comm_wake),
      .d_rx_din(d_rx_din), .d_rx_isk(d_rx_isk),
      .d_rx_elec_idle(d_rx_elec_idle),
      .d_comm_reset_detect(d_comm_reset_detect),
      .d_comm_wake_detect(d_comm_wake_detect),
      .d_tx_dout(d_tx_dout), .d_tx_isk(d_tx_isk),
      .d_tx_elec_idle(d_tx_elec_idle),
      .d_tx_comm_reset(d_tx_comm_reset), .d_tx_comm_wake(d_tx_comm_wake),
      .h_rx_din(h_rx_din), .h_rx_isk(h_rx_isk),
      .h_rx_elec_idle(h_rx_elec_idle),
      .h_comm_init_detect(h_comm_init_detect),
      .h_comm_wake_detect(h_comm_wake_detect),
      .inject_stb(inject_stb), .inject_dir(inject_dir),
      .inject_offset(inject_offset), .inject_mask(inject_mask),
      .inject_busy(inject_busy), .inject_done(inject_done),
      .inject_count(inject_count)
   );

   always #5 clk = ~clk;

   word_t         hh [N];
   word_t         dh [N];
   int            cyc = 0;
   int            last_rst = 0;
   int            passes = 0;
   int            checks = 0;
   word_t         hin, din;
   bit            rst_v = 1'b1;
   bit            stb_v = 1'b0;
   bit            dir_v = 1'b0;
   logic [7:0]    off_v = '0;
   logic [DW-1:0] mask_v = '0;
   bit            armed = 1'b0;
   bit            a_dir = 1'b0;
   int            a_rem = 0;
   logic [DW-1:0] a_mask = '0;
   int            count_m = 0;
   int            k = 0;

   function automatic word_t act(logic [DW-1:0] d);
      word_t w;
      w = '0;
      w.d = d;
      w.k = KW'($urandom);
      return w;
   endfunction

   function automatic word_t idl(logic [DW-1:0] d);
      word_t w;
      w = '0;
      w.d = d;
      w.k = KW'($urandom);
      w.ei = 1'b1;
      return w;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                  tag, cyc, obs, exp);
   endtask

   // One clock cycle: compare this cycle's outputs, then drive next inputs.
   task automatic step();
      word_t eh, ed;
      bit    done_e, busy_e, tgt_act;
      @(negedge clk);
      done_e = 1'b0;
      if (cyc >= L && last_rst < cyc - L) begin
         eh = hh[cyc-L];
         ed = dh[cyc-L];
      end else begin
         eh = '0; eh.ei = 1'b1;
         ed = '0; ed.ei = 1'b1;
      end
      if (eh.ei) begin eh.d = '0; eh.k = '0; end
      if (ed.ei) begin ed.d = '0; ed.k = '0; end
      busy_e = armed;
      if (armed) begin
         tgt_act = a_dir ? !ed.ei : !eh.ei;
         if (tgt_act) begin
            if (a_rem == 0) begin
               done_e = 1'b1;
               if (a_dir) ed.d = ed.d ^ a_mask;
               else eh.d = eh.d ^ a_mask;
            end else begin
               a_rem--;
            end
         end
      end
      check("d_rx_din", 64'(d_rx_din), 64'(eh.d));
      check("d_rx_isk", 64'(d_rx_isk), 64'(eh.k));
      check("d_rx_elec_idle", 64'(d_rx_elec_idle), 64'(eh.ei));
      check("d_comm_reset_detect", 64'(d_comm_reset_detect), 64'(eh.cr));
      check("d_comm_wake_detect", 64'(d_comm_wake_detect), 64'(eh.cw));
      check("h_rx_din", 64'(h_rx_din), 64'(ed.d));
      check("h_rx_isk", 64'(h_rx_isk), 64'(ed.k));
      check("h_rx_elec_idle", 64'(h_rx_elec_idle), 64'(ed.ei));
      check("h_comm_init_detect", 64'(h_comm_init_detect), 64'(ed.cr));
      check("h_comm_wake_detect", 64'(h_comm_wake_detect), 64'(ed.cw));
      check("inject_busy", 64'(inject_busy), 64'(busy_e));
      check("inject_done", 64'(inject_done), 64'(done_e));
      check("inject_count", 64'(inject_count), 64'(count_m));
      if (done_e) begin
         armed = 1'b0;
         if (count_m < CMAX) count_m++;
      end
      {h_tx_dout, h_tx_isk, h_tx_elec_idle, h_tx_comm_reset, h_tx_comm_wake} = hin;
      {d_tx_dout, d_tx_isk, d_tx_elec_idle, d_tx_comm_reset, d_tx_comm_wake} = din;
      rst           = rst_v;
      inject_stb    = stb_v;
      inject_dir    = dir_v;
      inject_offset = off_v;
      inject_mask   = mask_v;
      if (rst_v) begin
         last_rst = cyc;
         armed    = 1'b0;
         count_m  = 0;
      end else if (stb_v && !busy_e && INJ) begin
         armed  = 1'b1;
         a_dir  = dir_v;
         a_rem  = int'(off_v);
         a_mask = mask_v;
      end
      hh[cyc] = hin;
      dh[cyc] = din;
      cyc++;
   endtask

   task automatic arm(bit dir, logic [7:0] off, logic [DW-1:0] m);
      stb_v = 1'b1; dir_v = dir; off_v = off; mask_v = m;
   endtask

   initial begin
      hin = idl('0);
      din = idl('0);
      // reset state
      repeat (3) step();
      rst_v = 1'b0;
      repeat (6) begin hin = act($urandom); din = act($urandom); step(); end
      // latency of a known word, device side idle
      din = idl($urandom);
      hin = act(32'h12345678); step();
      hin = act($urandom); repeat (L + 1) step();
      // idle forcing and OOB pulses
      hin = '{d: 32'hFFFFFFFF, k: 4'hF, ei: 1'b1, cr: 1'b0, cw: 1'b0};
      repeat (3) step();
      hin.cr = 1'b1; repeat (2) step();
      hin.cr = 1'b0; din.cw = 1'b1; step();
      din.cw = 1'b0; hin.cw = 1'b1; din.cr = 1'b1; step();
      hin.cw = 1'b0; din.cr = 1'b0; repeat (L + 1) step();
      // injection on a counting device stream, offset 3
      arm(1'b1, 8'd3, 32'h00000001);
      din = act(32'(k++)); hin = act($urandom); step();
      stb_v = 1'b0;
      repeat (12) begin din = act(32'(k++)); hin = act($urandom); step(); end
      // idle words in the armed direction do not consume the offset
      din = idl($urandom); repeat (L) step();
      arm(1'b1, 8'd2, 32'h80000001);
      din = act(32'(k++)); hin = act($urandom); step();
      stb_v = 1'b0;
      repeat (5) begin din = idl($urandom); hin = act($urandom); step(); end
      repeat (10) begin din = act(32'(k++)); hin = act($urandom); step(); end
      // re-arm while busy is ignored
      arm(1'b0, 8'd5, 32'h0000FF00);
      hin = act($urandom); din = act($urandom); step();
      arm(1'b1, 8'd0, 32'hFFFFFFFF);
      hin = act($urandom); din = act($urandom); step();
      stb_v = 1'b0;
      repeat (10) begin hin = act($urandom); din = act($urandom); step(); end
      // zero-mask injections drive the counter into saturation
      repeat (4) begin
         arm(1'($urandom), 8'd0, '0);
         hin = act($urandom); din = act($urandom); step();
         stb_v = 1'b0;
         repeat (L + 2) begin hin = act($urandom); din = act($urandom); step(); end
      end
      // reset while armed
      arm(1'b1, 8'd20, 32'h5A5A5A5A);
      hin = act($urandom); din = act($urandom); step();
      stb_v = 1'b0;
      repeat (3) begin hin = act($urandom); din = act($urandom); step(); end
      rst_v = 1'b1; repeat (2) step();
      rst_v = 1'b0;
      repeat (L + 3) begin hin = act($urandom); din = act($urandom); step(); end
      // randomized traffic, OOB, idles, injections and occasional reset
      repeat (400) begin
         hin = ($urandom_range(3) == 0) ? idl($urandom) : act($urandom);
         din = ($urandom_range(3) == 0) ? idl($urandom) : act($urandom);
         hin.cr = ($urandom_range(15) == 0); hin.cw = ($urandom_range(15) == 0);
         din.cr = ($urandom_range(15) == 0); din.cw = ($urandom_range(15) == 0);
         stb_v = ($urandom_range(12) == 0);
         dir_v = 1'($urandom);
         off_v = 8'($urandom_range(6));
         mask_v = $urandom;
         rst_v = ($urandom_range(150) == 0);
         step();
      end
      rst_v = 1'b0; stb_v = 1'b0;
      repeat (L + 1) step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
